step_pulse_generator: RTL and testbench
=======================================

STEP_PULSE_GENERATOR -- requirements
Module: step_pulse_generator

Interface
REQ-001 Parameter COUNT_WIDTH, default 16, width of the pulse count.
REQ-002 Parameter TIME_WIDTH, default 16, width of the period and high-time fields in clock_in cycles.
REQ-003 clock_in  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  reset is synchronous and active-high.
REQ-005 en  in  1  1 = run; 0 = freeze timers, state and outputs.
REQ-006 write  in  1  one-cycle strobe; loads count, period, high_time, mode.
REQ-007 initial_count  in  COUNT_WIDTH  number of pulses to emit.
REQ-008 period  in  TIME_WIDTH  pulse period in clock_in cycles.
REQ-009 high_time  in  TIME_WIDTH  pulse_out high duration in clock_in cycles.
REQ-010 mode  in  1  0 = one-shot (count pulses), 1 = continuous (ignore count).
REQ-011 abort  in  1  one-cycle strobe; stops the sequence immediately.
REQ-012 pulse_out  out  1  registered step pulse.
REQ-013 busy  out  1  1 while state is not IDLE.
REQ-014 tc  out  1  1 when remaining count == 0.
REQ-015 done  out  1  one-cycle strobe on normal one-shot completion.
REQ-016 remaining  out  COUNT_WIDTH  pulses not yet completed.

Function
REQ-017 The block SHALL implement states IDLE, HIGH and LOW.
REQ-018 In IDLE, write=1 SHALL latch all inputs. The next state SHALL be HIGH (pulse_out=1 from the next cycle) unless mode=0 and initial_count=0; in that case the block SHALL stay IDLE and pulse done one cycle later.
REQ-019 write while busy=1 SHALL be ignored.
REQ-020 The effective high time SHALL be max(high_time,1).
REQ-021 The effective period SHALL be max(period, effective high time + 1), so the LOW phase is at least 1 cycle.
REQ-022 HIGH SHALL last exactly the effective high time in enabled cycles, then go to LOW. remaining SHALL decrement by 1 on that transition when mode=0.
REQ-023 LOW SHALL last the effective period minus the effective high time, then go to HIGH. When mode=0 and remaining=0, it SHALL instead go to IDLE with done=1 for one cycle.
REQ-024 mode=1 SHALL repeat HIGH/LOW indefinitely, leave remaining unchanged and never assert done.
REQ-025 en=0 SHALL hold state, phase timer, remaining and pulse_out. Resumption SHALL continue the same phase with no lost or extra cycles.
REQ-026 abort=1 SHALL force IDLE and pulse_out=0 on the next edge, take precedence over write and en, and not assert done. remaining SHALL hold its value at abort.
REQ-027 A write and an abort in the same cycle SHALL result in IDLE with nothing loaded.
REQ-028 tc SHALL be combinational from remaining.
REQ-029 All other outputs SHALL be registered.
REQ-030 Timer arithmetic SHALL use TIME_WIDTH+1 bits so the effective period cannot overflow at high_time = all-ones.

Reset
REQ-031 On reset: state=IDLE, pulse_out=0, busy=0, done=0, remaining=0 (tc=1), and the latched period, high_time and mode are cleared.
REQ-032 reset SHALL take precedence over abort, write and en, including in the middle of a pulse.

Structure
REQ-033 Package step_pulse_pkg SHALL hold the state enum (IDLE, HIGH, LOW) and the mode constants MODE_ONESHOT=0 and MODE_CONTINUOUS=1.
REQ-034 Sub-module step_phase_timer SHALL provide the down-counter: load value, enable and zero flag, TIME_WIDTH+1 bits. It SHALL be instantiated once.

Verification
REQ-035 Basic one-shot: count=4, period=10, high_time=3, en=1 -> 4 pulses, each 3 cycles high and 7 low. done pulses once 40 cycles after the first HIGH cycle. Final remaining=0, tc=1.
REQ-036 Clamping: period=2, high_time=0 -> 1 cycle high, 1 cycle low. Period=3, high_time=5 -> 5 cycles high, 1 cycle low.
REQ-037 en gating: en dropped for 6 cycles in the middle of a HIGH phase -> total high width = effective high time + 6, and the pulse count is unchanged.
REQ-038 Continuous mode plus abort: mode=1 runs more than 10 pulses with remaining constant. abort in a HIGH cycle -> pulse_out=0 next cycle, busy=0, no done.
REQ-039 Boundary writes: count=0 in one-shot -> no pulse and one done strobe. write during busy -> ignored. write together with abort -> stays IDLE.
REQ-040 Reset in the middle of a pulse: reset during HIGH -> next cycle shows all reset values of REQ-031. A following write starts cleanly.

Source files
------------

// File: rtl/step_pulse_pkg.sv
// Shared types and constants for the step pulse generator.
package step_pulse_pkg;

  // Sequencer states: waiting for a command, driving the pulse high, or
  // holding the pulse low for the rest of the period.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Value of the mode input / latched mode bit.
  localparam logic MODE_ONESHOT    = 1'b0;
  localparam logic MODE_CONTINUOUS = 1'b1;

endpackage

// File: rtl/step_phase_timer.sv
// Loadable down-counter that times one HIGH or LOW phase.
// The counter is one bit wider than the time fields so that any effective
// phase length derived from them fits without wrapping.
module step_phase_timer #(
  parameter int TIME_WIDTH = 16
) (
  input  logic                clock_in,
  input  logic                reset,
  input  logic                load,
  input  logic [TIME_WIDTH:0] load_value,
  input  logic                enable,
  output logic                zero
);

  localparam logic [TIME_WIDTH:0] TIMER_ONE = 1;

  logic [TIME_WIDTH:0] count;

  // Load has priority over counting; the counter parks at zero.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && !zero) begin
      count <= count - TIMER_ONE;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/step_pulse_generator.sv
// Step pulse generator: emits a programmable number of pulses (one-shot) or
// an endless pulse train (continuous), with period and high time given in
// clock_in cycles. The phase length is kept in a single shared down-counter.
module step_pulse_generator
  import step_pulse_pkg::*;
#(
  parameter int COUNT_WIDTH = 16,
  parameter int TIME_WIDTH  = 16
) (
  input  logic                   clock_in,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   write,
  input  logic [COUNT_WIDTH-1:0] initial_count,
  input  logic [TIME_WIDTH-1:0]  period,
  input  logic [TIME_WIDTH-1:0]  high_time,
  input  logic                   mode,
  input  logic                   abort,
  output logic                   pulse_out,
  output logic                   busy,
  output logic                   tc,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] remaining
);

  localparam logic [TIME_WIDTH:0]    TIMER_ONE = 1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = 1;

  // Effective high time: a zero high time still produces a one-cycle pulse.
  function automatic logic [TIME_WIDTH:0] eff_high(input logic [TIME_WIDTH-1:0] h);
    logic [TIME_WIDTH:0] hx;
    hx = {1'b0, h};
    return (hx == '0) ? TIMER_ONE : hx;
  endfunction

  // Effective low time: the period is stretched so LOW lasts at least one
  // cycle. eh + 1 needs the extra bit when high_time is all ones.
  function automatic logic [TIME_WIDTH:0] eff_low(input logic [TIME_WIDTH-1:0] p,
                                                  input logic [TIME_WIDTH-1:0] h);
    logic [TIME_WIDTH:0] px;
    logic [TIME_WIDTH:0] eh;
    logic [TIME_WIDTH:0] eff_period;
    px         = {1'b0, p};
    eh         = eff_high(h);
    eff_period = (px > eh) ? px : (eh + TIMER_ONE);
    return eff_period - eh;
  endfunction

  // Registered state and configuration.
  state_t                 state;
  logic [TIME_WIDTH-1:0]  cfg_period;
  logic [TIME_WIDTH-1:0]  cfg_high;
  logic                   cfg_mode;

  // Next-state values from the decision logic.
  state_t                 state_next;
  logic                   pulse_next;
  logic                   busy_next;
  logic                   done_next;
  logic [COUNT_WIDTH-1:0] remaining_next;
  logic                   cfg_load;

  // Phase timer controls.
  logic                   timer_load;
  logic [TIME_WIDTH:0]    timer_value;
  logic                   timer_dec;
  logic                   timer_zero;

  step_phase_timer #(
    .TIME_WIDTH (TIME_WIDTH)
  ) u_phase_timer (
    .clock_in   (clock_in),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .enable     (timer_dec),
    .zero       (timer_zero)
  );

  // State, outputs and configuration registers; reset wins over everything.
  // NOTE: the configuration registers are cleared on reset too, so no stale
  // period or mode survives into the next command.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state      <= IDLE;
      pulse_out  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      remaining  <= '0;
      cfg_period <= '0;
      cfg_high   <= '0;
      cfg_mode   <= MODE_ONESHOT;
    end else begin
      state     <= state_next;
      pulse_out <= pulse_next;
      busy      <= busy_next;
      done      <= done_next;
      remaining <= remaining_next;
      if (cfg_load) begin
        cfg_period <= period;
        cfg_high   <= high_time;
        cfg_mode   <= mode;
      end
    end
  end

  // Next-state and phase-timer control. Abort beats write and en; with en
  // low everything holds, including a write that would start a sequence.
  // NOTE: every signal gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_next     = state;
    pulse_next     = pulse_out;
    done_next      = 1'b0;
    remaining_next = remaining;
    cfg_load       = 1'b0;
    timer_load     = 1'b0;
    timer_value    = '0;
    timer_dec      = 1'b0;

    if (abort) begin
      state_next = IDLE;
      pulse_next = 1'b0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (write) begin
            cfg_load       = 1'b1;
            remaining_next = initial_count;
            if (mode == MODE_ONESHOT && initial_count == '0) begin
              done_next = 1'b1;
            end else begin
              state_next  = HIGH;
              pulse_next  = 1'b1;
              timer_load  = 1'b1;
              timer_value = eff_high(high_time) - TIMER_ONE;
            end
          end
        end

        HIGH: begin
          if (timer_zero) begin
            state_next  = LOW;
            pulse_next  = 1'b0;
            timer_load  = 1'b1;
            timer_value = eff_low(cfg_period, cfg_high) - TIMER_ONE;
            if (cfg_mode == MODE_ONESHOT) begin
              remaining_next = remaining - COUNT_ONE;
            end
          end else begin
            timer_dec = 1'b1;
          end
        end

        LOW: begin
          if (timer_zero) begin
            if (cfg_mode == MODE_ONESHOT && remaining == '0) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              state_next  = HIGH;
              pulse_next  = 1'b1;
              timer_load  = 1'b1;
              timer_value = eff_high(cfg_high) - TIMER_ONE;
            end
          end else begin
            timer_dec = 1'b1;
          end
        end

        default: begin
          state_next = IDLE;
          pulse_next = 1'b0;
        end
      endcase
    end

    busy_next = (state_next != IDLE);
  end

  assign tc = (remaining == '0);

endmodule

// File: tb/tb_step_pulse_generator.sv
// Self-checking bench for step_pulse_generator. Each test pushes the pulse
// widths, remaining values and done timing it expects into a scoreboard when
// it issues a command; the drain task measures the DUT and pops/compares.
module tb_step_pulse_generator;

  localparam int CW    = 16;
  localparam int TW    = 16;
  localparam int LIMIT = 300;

  logic          clock_in = 1'b0;
  logic          reset;
  logic          en;
  logic          write;
  logic [CW-1:0] initial_count;
  logic [TW-1:0] period;
  logic [TW-1:0] high_time;
  logic          mode;
  logic          abort;
  logic          pulse_out;
  logic          busy;
  logic          tc;
  logic          done;
  logic [CW-1:0] remaining;

  typedef enum {E_HIGH, E_LOW, E_REM, E_DONE} kind_t;
  typedef struct {
    kind_t kind;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   failed    = 0;
  int   elapsed   = 0;
  int   done_seen = 0;

  step_pulse_generator #(
    .COUNT_WIDTH (CW),
    .TIME_WIDTH  (TW)
  ) dut (
    .clock_in      (clock_in),
    .reset         (reset),
    .en            (en),
    .write         (write),
    .initial_count (initial_count),
    .period        (period),
    .high_time     (high_time),
    .mode          (mode),
    .abort         (abort),
    .pulse_out     (pulse_out),
    .busy          (busy),
    .tc            (tc),
    .done          (done),
    .remaining     (remaining)
  );

  initial forever #5 clock_in = ~clock_in;

  always @(negedge clock_in) if (done === 1'b1) done_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic push(input kind_t k, input int v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  // Issue a command from a negedge; returns at the negedge of the first
  // cycle after the write edge.
  task automatic write_cfg(input int cnt, input int per, input int ht, input logic md);
    initial_count = CW'(cnt);
    period        = TW'(per);
    high_time     = TW'(ht);
    mode          = md;
    write         = 1'b1;
    @(negedge clock_in);
    write   = 1'b0;
    elapsed = 0;
  endtask

  // Count consecutive negedge samples at the given level while busy.
  task automatic count_level(input logic level, output int n);
    n = 0;
    while (pulse_out === level && busy === 1'b1 && n < LIMIT) begin
      n++;
      @(negedge clock_in);
    end
  endtask

  task automatic drain_scoreboard(input string scen);
    exp_t e;
    int   n;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        E_HIGH, E_LOW: begin
          count_level(e.kind == E_HIGH, n);
          elapsed += n;
          tests_run++;
          if (n != e.val) begin
            failed++;
            $display("FAIL %s %s width: got %0d expected %0d", scen,
                     (e.kind == E_HIGH) ? "high" : "low", n, e.val);
          end
        end
        E_REM: begin
          tests_run++;
          if (remaining !== CW'(e.val) || tc !== (e.val == 0)) begin
            failed++;
            $display("FAIL %s remaining/tc: got %0d/%b expected %0d/%b", scen,
                     remaining, tc, e.val, (e.val == 0));
          end
        end
        E_DONE: begin
          tests_run++;
          if (done !== 1'b1 || elapsed != e.val) begin
            failed++;
            $display("FAIL %s done: got done=%b at cycle %0d expected done=1 at cycle %0d",
                     scen, done, elapsed, e.val);
          end
          @(negedge clock_in);
          tests_run++;
          if (done !== 1'b0 || busy !== 1'b0 || pulse_out !== 1'b0) begin
            failed++;
            $display("FAIL %s after done: got done=%b busy=%b pulse=%b expected 0/0/0",
                     scen, done, busy, pulse_out);
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; write = 1'b0; abort = 1'b0; mode = 1'b0;
    initial_count = '0; period = '0; high_time = '0;
    repeat (3) @(negedge clock_in);
    reset = 1'b0;
    tests_run++;
    if (pulse_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        remaining !== '0 || tc !== 1'b1) begin
      failed++;
      $display("FAIL reset values: got pulse=%b busy=%b done=%b rem=%0d tc=%b expected 0/0/0/0/1",
               pulse_out, busy, done, remaining, tc);
    end
  endtask

  task automatic test_one_shot();
    write_cfg(4, 10, 3, 1'b0);
    for (int k = 4; k >= 1; k--) begin
      push(E_REM, k);
      push(E_HIGH, 3);
      push(E_REM, k - 1);
      push(E_LOW, 7);
    end
    push(E_DONE, 40);
    push(E_REM, 0);
    drain_scoreboard("one_shot");
  endtask

  task automatic test_clamp();
    write_cfg(2, 2, 0, 1'b0);
    repeat (2) begin push(E_HIGH, 1); push(E_LOW, 1); end
    push(E_DONE, 4);
    drain_scoreboard("clamp_p2_h0");
    write_cfg(1, 3, 5, 1'b0);
    push(E_HIGH, 5);
    push(E_LOW, 1);
    push(E_DONE, 6);
    drain_scoreboard("clamp_p3_h5");
  endtask

  task automatic test_en_gating();
    int n;
    int m;
    write_cfg(2, 10, 3, 1'b0);
    n = 1;
    @(negedge clock_in);
    n += int'(pulse_out);
    en = 1'b0;
    repeat (6) begin
      @(negedge clock_in);
      n += int'(pulse_out);
    end
    tests_run++;
    if (busy !== 1'b1 || remaining !== CW'(2)) begin
      failed++;
      $display("FAIL en_gating frozen: got busy=%b rem=%0d expected 1/2", busy, remaining);
    end
    en = 1'b1;
    @(negedge clock_in);
    count_level(1'b1, m);
    n += m;
    elapsed = n;
    tests_run++;
    if (n != 9) begin
      failed++;
      $display("FAIL en_gating high width: got %0d expected 9", n);
    end
    push(E_REM, 1);
    push(E_LOW, 7);
    push(E_HIGH, 3);
    push(E_LOW, 7);
    push(E_DONE, 26);
    push(E_REM, 0);
    drain_scoreboard("en_gating");
  endtask

  task automatic test_continuous_abort();
    int done_before;
    done_before = done_seen;
    write_cfg(5, 4, 2, 1'b1);
    repeat (12) begin push(E_HIGH, 2); push(E_LOW, 2); end
    push(E_REM, 5);
    drain_scoreboard("continuous");
    tests_run++;
    if (pulse_out !== 1'b1 || done_seen != done_before) begin
      failed++;
      $display("FAIL continuous running: got pulse=%b dones=%0d expected 1/%0d",
               pulse_out, done_seen - done_before, 0);
    end
    abort = 1'b1;
    @(negedge clock_in);
    abort = 1'b0;
    tests_run++;
    if (pulse_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || remaining !== CW'(5)) begin
      failed++;
      $display("FAIL abort: got pulse=%b busy=%b done=%b rem=%0d expected 0/0/0/5",
               pulse_out, busy, done, remaining);
    end
    repeat (3) @(negedge clock_in);
    tests_run++;
    if (busy !== 1'b0 || done_seen != done_before) begin
      failed++;
      $display("FAIL abort idle: got busy=%b dones=%0d expected 0/0", busy,
               done_seen - done_before);
    end
  endtask

  task automatic test_boundary_writes();
    int n;
    int m;
    write_cfg(0, 5, 2, 1'b0);
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || pulse_out !== 1'b0 || remaining !== '0) begin
      failed++;
      $display("FAIL count0 done: got done=%b busy=%b pulse=%b rem=%0d expected 1/0/0/0",
               done, busy, pulse_out, remaining);
    end
    @(negedge clock_in);
    tests_run++;
    if (done !== 1'b0 || pulse_out !== 1'b0) begin
      failed++;
      $display("FAIL count0 after: got done=%b pulse=%b expected 0/0", done, pulse_out);
    end

    write_cfg(1, 6, 2, 1'b0);
    initial_count = CW'(9); period = TW'(20); high_time = TW'(10); mode = 1'b1;
    write = 1'b1;
    n = 1;
    @(negedge clock_in);
    write = 1'b0;
    count_level(1'b1, m);
    n += m;
    elapsed = n;
    tests_run++;
    if (n != 2) begin
      failed++;
      $display("FAIL busy_write high width: got %0d expected 2", n);
    end
    push(E_REM, 0);
    push(E_LOW, 4);
    push(E_DONE, 6);
    drain_scoreboard("busy_write");

    initial_count = CW'(3); period = TW'(6); high_time = TW'(2); mode = 1'b0;
    write = 1'b1;
    abort = 1'b1;
    @(negedge clock_in);
    write = 1'b0;
    abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || pulse_out !== 1'b0 || done !== 1'b0 || remaining !== '0) begin
      failed++;
      $display("FAIL write_abort: got busy=%b pulse=%b done=%b rem=%0d expected 0/0/0/0",
               busy, pulse_out, done, remaining);
    end
    @(negedge clock_in);
    tests_run++;
    if (busy !== 1'b0 || pulse_out !== 1'b0) begin
      failed++;
      $display("FAIL write_abort late: got busy=%b pulse=%b expected 0/0", busy, pulse_out);
    end
  endtask

  task automatic test_reset_mid_pulse();
    write_cfg(3, 8, 4, 1'b0);
    @(negedge clock_in);
    tests_run++;
    if (pulse_out !== 1'b1 || remaining !== CW'(3)) begin
      failed++;
      $display("FAIL pre_reset: got pulse=%b rem=%0d expected 1/3", pulse_out, remaining);
    end
    reset = 1'b1;
    write = 1'b1;
    abort = 1'b1;
    @(negedge clock_in);
    reset = 1'b0;
    write = 1'b0;
    abort = 1'b0;
    tests_run++;
    if (pulse_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        remaining !== '0 || tc !== 1'b1) begin
      failed++;
      $display("FAIL mid_reset: got pulse=%b busy=%b done=%b rem=%0d tc=%b expected 0/0/0/0/1",
               pulse_out, busy, done, remaining, tc);
    end
    write_cfg(1, 5, 2, 1'b0);
    push(E_REM, 1);
    push(E_HIGH, 2);
    push(E_LOW, 3);
    push(E_DONE, 5);
    push(E_REM, 0);
    drain_scoreboard("after_reset");
  endtask

  initial begin
    @(negedge clock_in);
    test_reset();
    test_one_shot();
    test_clamp();
    test_en_gating();
    test_continuous_abort();
    test_boundary_writes();
    test_reset_mid_pulse();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
